// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, baud-to-divisor lookup and FSM state encoding.
package uart_pkg;
    localparam int unsigned SYS_CLK_DEF = 50_000_000;
    localparam int DIV_W = 16;
    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_e;
    function automatic int unsigned baud_rate(input logic [2:0] sel);
        return sel == 3'd1 ? 19200 : sel == 3'd2 ? 38400 : sel == 3'd3 ? 57600 :
               sel == 3'd4 ? 115200 : 9600;
    endfunction
    // Codes 5-7 fall back to def_sel; an out-of-range def_sel falls back to 9600.
    function automatic logic [DIV_W-1:0] baud_div(input int unsigned sys_clk, input logic [2:0] sel,
                                                  input logic [2:0] def_sel);
        logic [2:0] s;
        s = sel > 3'd4 ? (def_sel > 3'd4 ? 3'd0 : def_sel) : sel;
        return DIV_W'(sys_clk / baud_rate(s) - 1);
    endfunction
    localparam logic [DIV_W-1:0] DIV_TABLE [0:4] = '{
        baud_div(SYS_CLK_DEF, 3'd0, 3'd0), baud_div(SYS_CLK_DEF, 3'd1, 3'd0),
        baud_div(SYS_CLK_DEF, 3'd2, 3'd0), baud_div(SYS_CLK_DEF, 3'd3, 3'd0),
        baud_div(SYS_CLK_DEF, 3'd4, 3'd0)};
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: latches the divisor for the selected baud code and times bit periods.
import uart_pkg::*;
module uart_baud_gen #(
    parameter int unsigned SYS_CLK = SYS_CLK_DEF,
    parameter logic [2:0] DEF_BAUD_SEL = 3'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] baud_set_i,
    input  logic       load_i,
    input  logic       en_i,
    output logic       bit_tick_o
);
    // Divisors are elaboration-time constants, so no runtime divider is built.
    localparam logic [DIV_W-1:0] DIV_TAB [0:7] = '{
        baud_div(SYS_CLK, 3'd0, DEF_BAUD_SEL), baud_div(SYS_CLK, 3'd1, DEF_BAUD_SEL),
        baud_div(SYS_CLK, 3'd2, DEF_BAUD_SEL), baud_div(SYS_CLK, 3'd3, DEF_BAUD_SEL),
        baud_div(SYS_CLK, 3'd4, DEF_BAUD_SEL), baud_div(SYS_CLK, 3'd5, DEF_BAUD_SEL),
        baud_div(SYS_CLK, 3'd6, DEF_BAUD_SEL), baud_div(SYS_CLK, 3'd7, DEF_BAUD_SEL)};
    logic [DIV_W-1:0] div_q, div_d, cnt_q, cnt_d;
    always_comb begin
        div_d      = load_i ? DIV_TAB[baud_set_i] : div_q;
        bit_tick_o = en_i && cnt_q == div_q;
        cnt_d      = (!en_i || bit_tick_o) ? '0 : cnt_q + 1'b1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            cnt_q <= '0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8N1 UART byte transmitter with selectable baud rate.
import uart_pkg::*;
module uart_byte_tx #(
    parameter int unsigned SYS_CLK = SYS_CLK_DEF,
    parameter logic [2:0] DEF_BAUD_SEL = 3'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] baud_set,
    input  logic       send_en,
    input  logic [7:0] data_byte,
    output logic       rs232_tx,
    output logic       tx_done,
    output logic       uart_state
);
    uart_state_e state_q, state_d;
    logic [7:0] sh_q, sh_d;
    logic [2:0] idx_q, idx_d;
    logic       tx_q, tx_d, done_q, done_d, load, tick;
    uart_baud_gen #(.SYS_CLK(SYS_CLK), .DEF_BAUD_SEL(DEF_BAUD_SEL)) u_baud (
        .clk        (clk),
        .rst        (rst),
        .baud_set_i (baud_set),
        .load_i     (load),
        .en_i       (state_q != ST_IDLE),
        .bit_tick_o (tick)
    );
    // tx_d follows the next state so the line changes on the same edge as the FSM.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        idx_d   = idx_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: if (send_en) begin
                state_d = ST_START;
                sh_d    = data_byte;
                idx_d   = '0;
                tx_d    = 1'b0;
                load    = 1'b1;
            end
            ST_START: if (tick) begin
                state_d = ST_DATA;
                tx_d    = sh_q[0];
                sh_d    = sh_q >> 1;
            end
            ST_DATA: if (tick) begin
                state_d = idx_q == 3'd7 ? ST_STOP : ST_DATA;
                tx_d    = idx_q == 3'd7 ? 1'b1 : sh_q[0];
                sh_d    = sh_q >> 1;
                idx_d   = idx_q + 3'd1;
            end
            default: if (tick) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end
    assign rs232_tx   = tx_q;
    assign tx_done    = done_q;
    assign uart_state = state_q != ST_IDLE;
endmodule
